// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - exhaustive 4-vector sweep sequencer and checker for a 2-input gate under test
module gate_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    localparam int ERR_W        = $clog2(4 * PASSES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       func_sel,
    input  logic             gut_out,
    output logic             drv_a,
    output logic             drv_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PC_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [PC_W-1:0]  PC_LAST    = PC_W'(PASSES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       vec;
    logic [1:0]       vec_next;
    logic [PC_W-1:0]  pass_cnt;
    logic [2:0]       func_lat;
    logic [3:0]       exp_tt;
    logic             mismatch;
    logic [ERR_W-1:0] err_next;

    logic             accept;
    logic             next_vec;
    logic             next_pass;
    logic             sample_en;

    // Expected output for each vector, indexed by {a,b}; bit v is the response to vector v.
    function automatic logic [3:0] truth_table(input logic [2:0] f);
        logic [3:0] tt;
        case (f)
            3'd0:    tt = 4'b0001; // NOR
            3'd1:    tt = 4'b0111; // NAND
            3'd2:    tt = 4'b1000; // AND
            3'd3:    tt = 4'b1110; // OR
            3'd4:    tt = 4'b0110; // XOR
            3'd5:    tt = 4'b1001; // XNOR
            3'd6:    tt = 4'b0011; // NOT A
            default: tt = 4'b1100; // BUF A
        endcase
        return tt;
    endfunction

    assign exp_tt   = truth_table(func_lat);
    // Case inequality so a floating or unknown gate output counts as a failure.
    assign mismatch = (gut_out !== exp_tt[vec]);
    assign err_next = err_count + ERR_W'(mismatch);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and sweep control strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        next_vec   = 1'b0;
        next_pass  = 1'b0;
        sample_en  = 1'b0;
        vec_next   = vec;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    accept     = 1'b1;
                    vec_next   = 2'd0;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    sample_en = 1'b1;
                    if (vec != 2'd3) begin
                        next_vec   = 1'b1;
                        vec_next   = vec + 2'd1;
                        state_next = SETTLE;
                    end else if (pass_cnt != PC_LAST) begin
                        next_pass  = 1'b1;
                        vec_next   = 2'd0;
                        state_next = SETTLE;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Settle timer: reloaded whenever a new vector is applied, counts down while settling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept || next_vec || next_pass) begin
            cnt <= CNT_RELOAD;
        end else if (state == SETTLE && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Vector index, pass counter and latched function select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec      <= 2'd0;
            pass_cnt <= '0;
            func_lat <= 3'd0;
        end else begin
            vec <= vec_next;
            if (accept) begin
                pass_cnt <= '0;
                func_lat <= func_sel;
            end else if (next_pass) begin
                pass_cnt <= pass_cnt + PC_W'(1);
            end
        end
    end

    // Result accumulation; an aborted sample never reaches here because sample_en stays low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            fail_vec  <= 4'd0;
            pass      <= 1'b0;
        end else if (accept) begin
            err_count <= '0;
            fail_vec  <= 4'd0;
            pass      <= 1'b0;
        end else if (sample_en) begin
            if (mismatch) begin
                err_count     <= err_next;
                fail_vec[vec] <= 1'b1;
            end
            if (state_next == DONE) begin
                pass <= (err_next == '0);
            end
        end
    end

    // Registered gate drive: follows the vector being applied, parked at 00 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drv_a <= 1'b0;
            drv_b <= 1'b0;
        end else if (state_next == SETTLE || state_next == SAMPLE) begin
            drv_a <= vec_next[1];
            drv_b <= vec_next[0];
        end else begin
            drv_a <= 1'b0;
            drv_b <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - scoreboard bench for gate_sweep_ctrl with a truth-table reference model
module tb_gate_sweep_ctrl;

    localparam int S    = 2;
    localparam int P    = 2;
    localparam int EW   = $clog2(4 * P + 1);
    localparam int RUNL = 4 * P * (S + 1);
    localparam int LAT  = RUNL + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [2:0]    func_sel = 3'd0;
    logic          gut_out;
    logic          drv_a, drv_b, busy, done, pass;
    logic [EW-1:0] err_count;
    logic [3:0]    fail_vec;
    logic [3:0]    gut_tt = 4'b0001;

    gate_sweep_ctrl #(.SETTLE_CYCLES(S), .PASSES(P)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .func_sel(func_sel), .gut_out(gut_out),
        .drv_a(drv_a), .drv_b(drv_b), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .fail_vec(fail_vec)
    );

    // Behavioural gate under test: arbitrary response table indexed by {a,b}.
    assign gut_out = gut_tt[{drv_a, drv_b}];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         done_cyc;
        logic [3:0] err;
        logic [3:0] fail;
        logic       pass;
    } exp_t;
    exp_t q[$];

    int   run_c0 = 0;
    bit   run_on = 1'b0;
    bit   pend_pass = 1'b0;
    logic exp_pass = 1'b0;
    int   mt;
    exp_t me;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic spec_out(input int f, input logic a, input logic b);
        case (f)
            0: return !(a || b);
            1: return !(a && b);
            2: return a && b;
            3: return a || b;
            4: return a ^ b;
            5: return !(a ^ b);
            6: return !a;
            default: return a;
        endcase
    endfunction

    function automatic logic [3:0] spec_tt(input int f);
        logic [3:0] r;
        for (int v = 0; v < 4; v++) begin
            logic [1:0] vv;
            vv = 2'(v);
            r[v] = spec_out(f, vv[1], vv[0]);
        end
        return r;
    endfunction

    // Monitor: checks drive sequence while a sweep runs and scores each done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (run_on) begin
                mt = cyc - run_c0;
                if (mt >= 1 && mt <= RUNL) begin
                    chk("drv", int'({drv_a, drv_b}), ((mt - 1) / (S + 1)) % 4);
                    chk("busy_run", int'(busy), 1);
                end
            end
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending sweep (cycle %0d)", cyc);
                end else begin
                    me = q.pop_front();
                    chk("done_cycle", cyc, me.done_cyc);
                    chk("err_count", int'(err_count), int'(me.err));
                    chk("fail_vec", int'(fail_vec), int'(me.fail));
                    chk("drv_done", int'({drv_a, drv_b}), 0);
                    exp_pass  = me.pass;
                    pend_pass = 1'b1;
                    run_on    = 1'b0;
                end
            end else if (pend_pass) begin
                chk("pass", int'(pass), int'(exp_pass));
                chk("busy_idle", int'(busy), 0);
                pend_pass = 1'b0;
            end
        end
    end

    task automatic launch(input int f, input logic [3:0] tt, output logic [3:0] diff);
        exp_t e;
        @(negedge clk);
        gut_tt   = tt;
        func_sel = 3'(f);
        abort    = 1'b0;
        start    = 1'b1;
        diff     = tt ^ spec_tt(f);
        run_c0   = cyc;
        run_on   = 1'b1;
        e.done_cyc = cyc + LAT;
        e.fail     = diff;
        e.err      = 4'(P * $countones(diff));
        e.pass     = (diff == 4'd0);
        q.push_back(e);
    endtask

    task automatic run_sweep(input int f, input logic [3:0] tt);
        logic [3:0] diff;
        bit got;
        launch(f, tt, diff);
        got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            start    = ($urandom_range(0, 3) == 0);
            func_sel = 3'($urandom_range(0, 7));
        end
        start = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL sweep_timeout: got no done expected done within 200 cycles");
            q.delete();
            run_on = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic abort_test(input int f, input logic [3:0] tt);
        logic [3:0] diff;
        exp_t dummy;
        launch(f, tt, diff);
        dummy = q.pop_back();
        repeat (4) begin
            @(negedge clk);
            start = ($urandom_range(0, 1) == 0);
        end
        @(negedge clk);
        start  = 1'b0;
        abort  = 1'b1;
        run_on = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_drv", int'({drv_a, drv_b}), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_pass", int'(pass), 0);
        chk("abort_err", int'(err_count), int'(diff[0]));
        chk("abort_fail", int'(fail_vec), int'({3'b000, diff[0]}));
        repeat (30) @(negedge clk);
        chk("abort_stays_idle", int'(busy), 0);
        chk("abort_err_hold", int'(err_count), int'(diff[0]));
    endtask

    initial begin
        logic [3:0] diff;
        exp_t dummy;
        int   f;

        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_fail", int'(fail_vec), 0);
        chk("rst_drv", int'({drv_a, drv_b}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(0, 4'b0001);
        run_sweep(0, 4'b0000);
        run_sweep(1, 4'b0001);
        run_sweep(0, 4'b1110);

        abort_test(0, 4'b0000);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", int'(busy), 0);
        @(negedge clk);
        chk("start_abort_drv", int'({drv_a, drv_b}), 0);
        chk("start_abort_busy2", int'(busy), 0);

        launch(0, 4'b0000, diff);
        dummy = q.pop_back();
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_err", int'(err_count), 1);
        run_on = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_drv", int'({drv_a, drv_b}), 0);
        chk("async_rst_err", int'(err_count), 0);
        chk("async_rst_fail", int'(fail_vec), 0);
        chk("async_rst_pass", int'(pass), 0);
        chk("async_rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(0, 4'b0001);

        for (int r = 0; r < 12; r++) begin
            f = $urandom_range(0, 7);
            case ($urandom_range(0, 2))
                0:       run_sweep(f, spec_tt(f));
                1:       run_sweep(f, ~spec_tt(f));
                default: run_sweep(f, 4'($urandom_range(0, 15)));
            endcase
        end
        abort_test($urandom_range(0, 7), 4'($urandom_range(0, 15)));
        run_sweep(5, 4'b1001);

        chk("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish before 1ms");
        $fatal(1);
    end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
- Sequencer that exhaustively exercises a 2-input switch-level CMOS gate under test (GUT), such as a NOR/NAND built from pmos/nmos primitives.
- Drives the GUT's A/B inputs through all four vectors, waits a programmable settle time, samples the GUT output, and checks it against the expected truth table for a selected function.
- Reports per-vector failures, an error count and pass/done status. Sits in the gate-level test harness between the bench/top-level control and the gate instance.

Parameters:
- SETTLE_CYCLES, 2, clock cycles each vector is held before sampling; legal range >= 1.
- PASSES, 1, number of full 4-vector sweeps per start; legal range >= 1.
- ERR_W, $clog2(4*PASSES+1), derived localparam; width of err_count. Not user-overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; honoured only in IDLE.
- abort  input  1  synchronous abort of a running sweep.
- func_sel  input  3  expected function: 0 NOR, 1 NAND, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6 NOT A, 7 BUF A.
- gut_out  input  1  output of the gate under test.
- drv_a  output  1  registered drive to GUT input A (= vector bit 1).
- drv_b  output  1  registered drive to GUT input B (= vector bit 0).
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  one-cycle pulse at sweep completion.
- pass  output  1  high after a completed sweep with zero errors; held until next accepted start.
- err_count  output  ERR_W  number of mismatching samples in the current/last sweep.
- fail_vec  output  4  bit v set if vector v mismatched in any pass.

Behaviour:
- Reset (async, rst_n=0): state IDLE; drv_a=drv_b=0; busy=0; done=0; pass=0; err_count=0; fail_vec=0. Vector index, pass counter and settle counter are all 0. Reset takes effect immediately, including mid-sweep.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 and abort=0 accepted: latch func_sel, clear err_count/fail_vec/pass, set v=0 and pass_cnt=0, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
  - start=1 with abort=1: start is ignored.
- SETTLE:
  - drv_a/drv_b = v[1]/v[0].
  - Counter decrements each cycle; at 0, go to SAMPLE.
- SAMPLE:
  - Compare gut_out against expected(func_latched, v) using 4-state inequality; gut_out of X or Z is a mismatch.
  - On mismatch: err_count += 1 and fail_vec[v] = 1.
  - If v<3: v+1, reload counter, go to SETTLE.
  - If v==3 and pass_cnt<PASSES-1: v=0, pass_cnt+1, reload, go to SETTLE.
  - Otherwise: go to DONE.
- DONE: done=1 for exactly this cycle; pass=(err_count==0); drv_a/drv_b return to 0; go to IDLE.
- Latency: if start is accepted at the edge ending cycle 0, vector k (k=0..4*PASSES-1) is sampled in cycle (k+1)*(SETTLE_CYCLES+1), and done is high in cycle 4*PASSES*(SETTLE_CYCLES+1)+1. Each vector is driven for SETTLE_CYCLES+1 cycles.
- start while busy or in DONE: ignored, with no effect on the sweep.
- abort=1 in SETTLE/SAMPLE: the next state is IDLE. No done pulse; pass stays 0; err_count/fail_vec keep their partial values; drv_a/drv_b go to 0. A sample taken in the abort cycle is discarded.
- abort in IDLE/DONE: no effect, except that in IDLE it blocks start.
- func_sel changes mid-sweep have no effect; the latched value is used.
- err_count cannot overflow; its maximum is 4*PASSES.

Test Plan:
- NOR GUT, func_sel=0, SETTLE_CYCLES=2, PASSES=1, start pulsed in cycle 0:
  - drv_a,drv_b = 00,01,10,11, each held 3 cycles.
  - done high in cycle 13 only; pass=1, err_count=0, fail_vec=0000.
- Same stimulus, gut_out forced 0:
  - Only the 00 vector mismatches.
  - done in cycle 13; pass=0, err_count=1, fail_vec=0001.
- NOR GUT with func_sel=1 (NAND expected):
  - Vectors 01 and 10 mismatch.
  - pass=0, err_count=2, fail_vec=0110.
- gut_out driven X, func_sel=0, PASSES=2:
  - All samples mismatch.
  - done in cycle 25; err_count=8, fail_vec=1111, pass=0.
- Abort and start while busy:
  - abort=1 in cycle 5: IDLE from cycle 6, busy=0, drv=00, no done, err_count holds partial value.
  - start pulses during the run are ignored.
  - start with abort=1 in IDLE: stays IDLE.
- rst_n low in cycle 7 mid-sweep: all outputs 0 immediately, without waiting for a clock edge. After release, a fresh start runs the full 13-cycle sweep.
